// File: rtl/byte_stream_packer.sv
// Packs IN_WIDTH input lanes into DATA_WIDTH words (lane 0 in the MSBs) behind a small output FIFO.
// Define PACKER_STATS_EN to add the pkt_count/word_count/drop_count statistics outputs.
module byte_stream_packer #(
    parameter int DATA_WIDTH = 480,
    parameter int CTRL_WIDTH = 32,
    parameter int IN_WIDTH   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   data_in,
    input  logic                  datavalid,
    input  logic                  newpkt,
    input  logic                  lastbyte,
    output logic                  in_rdy,
    output logic                  out_wr,
    output logic [CTRL_WIDTH-1:0] out_ctl,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_rdy,
    output logic                  err
`ifdef PACKER_STATS_EN
    ,
    output logic [31:0]           pkt_count,
    output logic [31:0]           word_count,
    output logic [15:0]           drop_count
`endif
);

    localparam int LANES    = DATA_WIDTH / IN_WIDTH;
    localparam int LANE0_SH = (LANES - 1) * IN_WIDTH;
    // One spare slot absorbs the double push of a truncation plus a one-lane packet.
    localparam int NSLOT    = FIFO_DEPTH + 1;
    localparam int PW       = $clog2(NSLOT);
    localparam int CW       = $clog2(NSLOT + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_e;

    state_e                state_q, state_d;

    logic [DATA_WIDTH-1:0] asm_data_q, asm_data_d;
    logic [7:0]            asm_cnt_q, asm_cnt_d;
    logic                  asm_sop_q, asm_sop_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] mem_data [NSLOT];
    logic [CTRL_WIDTH-1:0] mem_ctl  [NSLOT];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  acc;
    logic                  pop;
    logic                  push0, push1;
    logic [DATA_WIDTH-1:0] w0_data, w1_data;
    logic [CTRL_WIDTH-1:0] w0_ctl, w1_ctl;

    logic [DATA_WIDTH-1:0] lane_ext;
    logic [31:0]           lane_sh;
    logic                  trunc;
    logic                  c_take;
    logic                  c_done;
    logic [DATA_WIDTH-1:0] c_data;
    logic [7:0]            c_cnt;
    logic                  c_sop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(NSLOT - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [CTRL_WIDTH-1:0] mk_ctl(
        input logic       sop,
        input logic       eop,
        input logic       tr,
        input logic [7:0] n
    );
        logic [CTRL_WIDTH-1:0] c;
        c       = '0;
        c[0]    = sop;
        c[1]    = eop;
        c[2]    = tr;
        c[15:8] = n;
        return c;
    endfunction

    assign in_rdy   = cnt_q < CW'(FIFO_DEPTH);
    assign acc      = datavalid & in_rdy;
    assign out_wr   = cnt_q != '0;
    assign pop      = out_wr & out_rdy;
    assign out_data = out_wr ? mem_data[rd_ptr_q] : '0;
    assign out_ctl  = out_wr ? mem_ctl[rd_ptr_q] : '0;
    assign err      = err_q;

    assign lane_ext = DATA_WIDTH'(data_in);
    assign lane_sh  = 32'(LANE0_SH) - 32'(asm_cnt_q) * 32'(IN_WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (acc) begin
            unique case (state_q)
                IDLE: begin
                    if (newpkt && !lastbyte) begin
                        state_d = IN_PKT;
                    end
                end
                IN_PKT: begin
                    if (lastbyte) begin
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        asm_data_d = asm_data_q;
        asm_cnt_d  = asm_cnt_q;
        asm_sop_d  = asm_sop_q;
        err_d      = 1'b0;
        trunc      = 1'b0;
        c_take     = 1'b0;
        c_data     = '0;
        c_cnt      = '0;
        c_sop      = 1'b0;
        push0      = 1'b0;
        push1      = 1'b0;
        w0_data    = '0;
        w0_ctl     = '0;
        w1_data    = '0;
        w1_ctl     = '0;
        if (acc) begin
            unique case (state_q)
                IDLE: begin
                    if (newpkt) begin
                        c_take = 1'b1;
                        c_data = lane_ext << LANE0_SH;
                        c_cnt  = 8'd1;
                        c_sop  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                IN_PKT: begin
                    if (newpkt) begin
                        err_d  = 1'b1;
                        // Nothing to flush when the last full word already left.
                        trunc  = asm_cnt_q != 8'd0;
                        c_take = 1'b1;
                        c_data = lane_ext << LANE0_SH;
                        c_cnt  = 8'd1;
                        c_sop  = 1'b1;
                    end else begin
                        c_take = 1'b1;
                        c_data = asm_data_q | (lane_ext << lane_sh);
                        c_cnt  = asm_cnt_q + 8'd1;
                        c_sop  = asm_sop_q;
                    end
                end
            endcase
        end
        c_done = c_take && (lastbyte || c_cnt == 8'(LANES));
        if (trunc) begin
            push0   = 1'b1;
            w0_data = asm_data_q;
            w0_ctl  = mk_ctl(asm_sop_q, 1'b1, 1'b1, asm_cnt_q);
        end
        if (c_done) begin
            if (trunc) begin
                push1   = 1'b1;
                w1_data = c_data;
                w1_ctl  = mk_ctl(c_sop, lastbyte, 1'b0, c_cnt);
            end else begin
                push0   = 1'b1;
                w0_data = c_data;
                w0_ctl  = mk_ctl(c_sop, lastbyte, 1'b0, c_cnt);
            end
            asm_data_d = '0;
            asm_cnt_d  = 8'd0;
            asm_sop_d  = 1'b0;
        end else if (c_take) begin
            asm_data_d = c_data;
            asm_cnt_d  = c_cnt;
            asm_sop_d  = c_sop;
        end
    end

    always_comb begin
        cnt_d    = cnt_q + CW'(push0) + CW'(push1) - CW'(pop);
        rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push1) begin
            wr_ptr_d = nxt(nxt(wr_ptr_q));
        end else if (push0) begin
            wr_ptr_d = nxt(wr_ptr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_data_q <= '0;
            asm_cnt_q  <= 8'd0;
            asm_sop_q  <= 1'b0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            asm_data_q <= asm_data_d;
            asm_cnt_q  <= asm_cnt_d;
            asm_sop_q  <= asm_sop_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push0) begin
            mem_data[wr_ptr_q] <= w0_data;
            mem_ctl[wr_ptr_q]  <= w0_ctl;
        end
        if (push1) begin
            mem_data[nxt(wr_ptr_q)] <= w1_data;
            mem_ctl[nxt(wr_ptr_q)]  <= w1_ctl;
        end
    end

`ifdef PACKER_STATS_EN
    logic [31:0] pkt_count_q;
    logic [31:0] word_count_q;
    logic [15:0] drop_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count_q  <= '0;
            word_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            if (pop) begin
                word_count_q <= word_count_q + 32'd1;
                if (out_ctl[1]) begin
                    pkt_count_q <= pkt_count_q + 32'd1;
                end
            end
            if (err_d && drop_count_q != 16'hFFFF) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end

    assign pkt_count  = pkt_count_q;
    assign word_count = word_count_q;
    assign drop_count = drop_count_q;
`endif

endmodule
